// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub_pkg
// Shared constants for the pipelined add/subtract unit and anything that drives it.
// MODE_ADD / MODE_SUB are the encodings of the 'sub' operand-mode bit.
package pipe_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if
// Operand/result handshake bundle for pipe_addsub.
//   in_valid/in_ready : operand beat handshake (a, b, cin, sub travel with it)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf travel with it)
// master : operand producer / result consumer side
// slave  : the arithmetic unit
interface pipe_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipe_addsub_stage.sv
// pipe_addsub_stage
// One CW-bit chunk of the carry-chained adder with its own pipeline register.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : global advance; when low every register holds
//   v_in      : valid bit of the beat entering this chunk
//   a_c, b_c  : operand chunks (b_c already inverted for subtract)
//   c_in      : carry from the chunk below (or the operation carry-in)
//   v_out     : registered valid bit
//   s_out     : registered sum chunk
//   c_out     : registered carry out of this chunk
//   ovf_out   : registered signed-overflow flag (only when OVF_EN, else 0)
module pipe_addsub_stage #(
    parameter int CW     = 4,
    parameter bit OVF_EN = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          v_in,
    input  logic [CW-1:0] a_c,
    input  logic [CW-1:0] b_c,
    input  logic          c_in,
    output logic          v_out,
    output logic [CW-1:0] s_out,
    output logic          c_out,
    output logic          ovf_out
);

    logic [CW:0] total_s;
    logic        ovf_next_s;

    // Chunk adder, one bit wider so the chunk carry is the top bit
    always_comb begin
        total_s = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, c_in};
    end

    // Overflow only means something in the chunk that holds the word MSB
    always_comb begin
        if (OVF_EN) begin
            ovf_next_s = (a_c[CW-1] == b_c[CW-1]) && (total_s[CW-1] != a_c[CW-1]);
        end else begin
            ovf_next_s = 1'b0;
        end
    end

    // Chunk pipeline register; en low freezes the beat in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_out   <= 1'b0;
            s_out   <= '0;
            c_out   <= 1'b0;
            ovf_out <= 1'b0;
        end else if (en) begin
            v_out   <= v_in;
            s_out   <= total_s[CW-1:0];
            c_out   <= total_s[CW];
            ovf_out <= ovf_next_s;
        end
    end

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub
// Pipelined WIDTH-bit add/subtract unit split into STAGES carry-chained chunks,
// one chunk per register stage, with valid/ready handshake and backpressure.
// WIDTH must be a multiple of STAGES.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset, flushes every in-flight beat
//   bus  : pipe_addsub_if.slave (operands a, b, cin, sub in; sum, cout, ovf out)
// sub=MODE_ADD gives a+b+cin; sub=MODE_SUB gives a+~b+1 (cin ignored).
// Every stage advances together: no bubble collapsing, so a stalled output
// freezes the whole pipe.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    pipe_addsub_if.slave  bus
);

    localparam int CW = WIDTH / STAGES;

    logic              adv_s;
    logic [STAGES-1:0] ovf_vec_s;

    // The pipe moves whenever the output slot is empty or being drained
    always_comb begin
        adv_s = !bus.out_valid || bus.out_ready;
    end

    assign bus.in_ready = adv_s;

    // Stage k adds chunk k. Its operands (chunk k and everything above it)
    // arrive in a_op_s/bp_op_s with chunk k in the low CW bits; the upper part
    // is forwarded into the next stage's delay registers. sum_acc_s is the
    // registered result so far, chunks 0..k.
    for (genvar k = 0; k < STAGES; k++) begin : stage_g
        localparam int OP_W = WIDTH - k * CW;

        logic [OP_W-1:0]       a_op_s;
        logic [OP_W-1:0]       bp_op_s;
        logic                  c_in_s;
        logic                  v_in_s;
        logic                  v_s;
        logic                  c_s;
        logic [CW-1:0]         chunk_s;
        logic [(k+1)*CW-1:0]   sum_acc_s;

        if (k == 0) begin : first_g
            // Entry: subtract folds into the adder as ~b with carry-in forced to 1
            always_comb begin
                a_op_s = bus.a;
                if (bus.sub == MODE_SUB) begin
                    bp_op_s = ~bus.b;
                    c_in_s  = 1'b1;
                end else begin
                    bp_op_s = bus.b;
                    c_in_s  = bus.cin;
                end
                v_in_s    = bus.in_valid;
                sum_acc_s = chunk_s;
            end
        end else begin : next_g
            logic [OP_W-1:0]   a_hi_r;
            logic [OP_W-1:0]   bp_hi_r;
            logic [k*CW-1:0]   sum_low_r;

            // Delay registers: pending operand chunks travel beside the carry of
            // the previous chunk; finished low sum chunks travel beside chunk k
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_hi_r    <= '0;
                    bp_hi_r   <= '0;
                    sum_low_r <= '0;
                end else if (adv_s) begin
                    a_hi_r    <= stage_g[k-1].a_op_s[WIDTH-(k-1)*CW-1:CW];
                    bp_hi_r   <= stage_g[k-1].bp_op_s[WIDTH-(k-1)*CW-1:CW];
                    sum_low_r <= stage_g[k-1].sum_acc_s;
                end
            end

            // Chain this stage onto the registered outputs of the one below
            always_comb begin
                a_op_s    = a_hi_r;
                bp_op_s   = bp_hi_r;
                c_in_s    = stage_g[k-1].c_s;
                v_in_s    = stage_g[k-1].v_s;
                sum_acc_s = {chunk_s, sum_low_r};
            end
        end

        pipe_addsub_stage #(
            .CW     (CW),
            .OVF_EN (k == STAGES - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (adv_s),
            .v_in    (v_in_s),
            .a_c     (a_op_s[CW-1:0]),
            .b_c     (bp_op_s[CW-1:0]),
            .c_in    (c_in_s),
            .v_out   (v_s),
            .s_out   (chunk_s),
            .c_out   (c_s),
            .ovf_out (ovf_vec_s[k])
        );
    end

    // Results come straight from the final stage registers. Only the top
    // chunk stage can raise its overflow flag, so an OR picks it out.
    assign bus.out_valid = stage_g[STAGES-1].v_s;
    assign bus.sum       = stage_g[STAGES-1].sum_acc_s;
    assign bus.cout      = stage_g[STAGES-1].c_s;
    assign bus.ovf       = |ovf_vec_s;

endmodule

// File: tb/tb_pipe_addsub.sv
`timescale 1ns/1ps
module tb_pipe_addsub;
    import pipe_addsub_pkg::*;

    typedef struct {
        int sum;
        int cout;
        int ovf;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   chk_lat   = 1'b0;
    bit   rnd_ready = 1'b0;
    bit   ready_cmd = 1'b1;
    exp_t q8[$];
    exp_t q3[$];
    exp_t m8;
    exp_t m3;
    int   pushed8 = 0, popped8 = 0, pushed3 = 0, popped3 = 0;

    pipe_addsub_if #(.WIDTH(8)) bus8 ();
    pipe_addsub_if #(.WIDTH(3)) bus3 ();

    pipe_addsub #(.WIDTH(8), .STAGES(2)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    pipe_addsub #(.WIDTH(3), .STAGES(1)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: plain integer arithmetic on the mathematical operation
    function automatic exp_t model(input int w, input int a, input int b,
                                   input int c, input int s, input int acc);
        exp_t e;
        int m, full, sa, sb, r;
        m = 1 << w;
        if (s == int'(MODE_SUB)) full = a + (m - b);   // a - b + 2^w
        else                     full = a + b + c;
        e.sum  = full % m;
        e.cout = (full >= m) ? 1 : 0;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        r  = (s == int'(MODE_SUB)) ? sa - sb : sa + sb + c;
        e.ovf = ((r > m / 2 - 1) || (r < -(m / 2))) ? 1 : 0;
        e.acc = acc;
        return e;
    endfunction

    // out_ready drivers: scripted or random, updated 2ns after each rising edge
    initial begin
        forever begin
            if (rnd_ready) begin
                bus8.out_ready = ($urandom_range(0, 3) != 0);
                bus3.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus8.out_ready = ready_cmd;
                bus3.out_ready = 1'b1;
            end
            @(posedge clk);
            #2;
        end
    end

    // Monitor: pop and compare whenever a result beat is handed over
    always @(negedge clk) begin
        if (!rst && bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
            if (q8.size() == 0) begin
                check("spurious8", int'(bus8.out_valid), 0);
            end else begin
                m8 = q8.pop_front();
                popped8++;
                check("sum8", int'(bus8.sum), m8.sum);
                check("cout8", int'(bus8.cout), m8.cout);
                check("ovf8", int'(bus8.ovf), m8.ovf);
                if (chk_lat) check("lat8", cyc - m8.acc, 2);
            end
        end
        if (!rst && bus3.out_valid === 1'b1 && bus3.out_ready === 1'b1) begin
            if (q3.size() == 0) begin
                check("spurious3", int'(bus3.out_valid), 0);
            end else begin
                m3 = q3.pop_front();
                popped3++;
                check("sum3", int'(bus3.sum), m3.sum);
                check("cout3", int'(bus3.cout), m3.cout);
                check("ovf3", int'(bus3.ovf), m3.ovf);
                if (chk_lat) check("lat3", cyc - m3.acc, 1);
            end
        end
    end

    task automatic send8(input int a, input int b, input int c, input int s);
        bit ok;
        int n, acc;
        bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = c[0]; bus8.sub = s[0];
        bus8.in_valid = 1'b1;
        ok = 1'b0; n = 0; acc = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok  = (bus8.in_ready === 1'b1);
            acc = cyc;
            @(posedge clk);
            n++;
        end
        if (ok) begin
            q8.push_back(model(8, a & 255, b & 255, c & 1, s & 1, acc));
            pushed8++;
        end else begin
            fail_now("accept8");
        end
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic send3(input int a, input int b, input int c, input int s);
        bit ok;
        int n, acc;
        bus3.a = a[2:0]; bus3.b = b[2:0]; bus3.cin = c[0]; bus3.sub = s[0];
        bus3.in_valid = 1'b1;
        ok = 1'b0; n = 0; acc = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok  = (bus3.in_ready === 1'b1);
            acc = cyc;
            @(posedge clk);
            n++;
        end
        if (ok) begin
            q3.push_back(model(3, a & 7, b & 7, c & 1, s & 1, acc));
            pushed3++;
        end else begin
            fail_now("accept3");
        end
        #1;
        bus3.in_valid = 1'b0;
    endtask

    // Idle cycles with junk on the don't-care operand lines
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus8.in_valid = 1'b0; bus3.in_valid = 1'b0;
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            bus3.a = 3'($urandom); bus3.b = 3'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        rnd_ready = 1'b0;
        ready_cmd = 1'b1;
        n = 0;
        while ((q8.size() != 0 || q3.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) fail_now("drain");
        idle(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0; bus8.sub = 1'b0;
        bus3.in_valid = 1'b0; bus3.a = 3'h0;  bus3.b = 3'h0;  bus3.cin = 1'b0; bus3.sub = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid8", int'(bus8.out_valid), 0);
        check("rst_sum8", int'(bus8.sum), 0);
        check("rst_cout8", int'(bus8.cout), 0);
        check("rst_ovf8", int'(bus8.ovf), 0);
        check("rst_in_ready8", int'(bus8.in_ready), 1);
        check("rst_out_valid3", int'(bus3.out_valid), 0);
        check("rst_sum3", int'(bus3.sum), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic, unstalled, exact latency
        chk_lat = 1'b1;
        send8(8'h0F, 8'h01, 0, int'(MODE_ADD));
        idle(4);
        send8(8'hFF, 8'h01, 0, int'(MODE_ADD));
        send8(8'h7F, 8'h01, 0, int'(MODE_ADD));
        send8(8'h80, 8'hFF, 1, int'(MODE_ADD));
        send8(8'h06, 8'h02, 1, int'(MODE_SUB));
        send8(8'h02, 8'h06, 1, int'(MODE_SUB));
        send8(8'h80, 8'h01, 1, int'(MODE_SUB));
        send3(6, 2, 0, int'(MODE_ADD));
        send3(6, 1, 0, int'(MODE_ADD));
        send3(3, 5, 1, int'(MODE_SUB));
        idle(4);
        chk_lat = 1'b0;

        // Back-to-back burst into a stalled output
        p0 = popped8;
        ready_cmd = 1'b0;
        @(posedge clk); #3;
        fork
            begin
                send8(1, 1, 0, int'(MODE_ADD));
                send8(2, 2, 0, int'(MODE_ADD));
                send8(3, 3, 0, int'(MODE_ADD));
                send8(4, 4, 0, int'(MODE_ADD));
            end
            begin
                int n;
                n = 0;
                while (bus8.out_valid !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (bus8.out_valid !== 1'b1) fail_now("stall_first_result");
                for (int i = 0; i < 3; i++) begin
                    check("stall_sum", int'(bus8.sum), 2);
                    check("stall_valid", int'(bus8.out_valid), 1);
                    check("stall_in_ready", int'(bus8.in_ready), 0);
                    @(negedge clk);
                end
                ready_cmd = 1'b1;
            end
        join
        idle(6);
        check("burst_count", popped8 - p0, 4);

        // Asynchronous reset with two beats in flight
        send8(8'h11, 8'h22, 0, int'(MODE_ADD));
        send8(8'h33, 8'h44, 0, int'(MODE_ADD));
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", int'(bus8.out_valid), 0);
        check("arst_sum", int'(bus8.sum), 0);
        check("arst_cout", int'(bus8.cout), 0);
        q8.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", int'(bus8.out_valid), 0);
        end
        @(posedge clk); #1;

        // Randomized traffic with random backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send8($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        end
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send3($urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        end
        drain();

        check("left8", q8.size(), 0);
        check("left3", q3.size(), 0);
        check("popped8", popped8, pushed8 - 2);
        check("popped3", popped3, pushed3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
